// File: rtl/sa_cache_array.sv
// N-way set-associative tag/data/state array with true-LRU replacement and victim reporting.
// Define SA_CACHE_STATS_EN to add saturating hit/miss counters (stat_hits, stat_misses).
module sa_cache_array #(
    parameter int unsigned WAYS   = 4,
    parameter int unsigned SETS   = 256,
    parameter int unsigned TAG_W  = 18,
    parameter int unsigned LINE_W = 128,
    localparam int unsigned IDX_W = $clog2(SETS),
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [1:0]        req_op,
    input  logic [IDX_W-1:0]  req_index,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic [LINE_W-1:0] req_data,
    input  logic              req_dirty,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic [WAY_W-1:0]  rsp_way,
    output logic [LINE_W-1:0] rsp_data,
    output logic              rsp_victim_valid,
    output logic              rsp_victim_dirty,
    output logic [TAG_W-1:0]  rsp_victim_tag,
    output logic [LINE_W-1:0] rsp_victim_data
`ifdef SA_CACHE_STATS_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses
`endif
);

    logic [WAYS-1:0]   r_valid [SETS];
    logic [WAYS-1:0]   r_dirty [SETS];
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [LINE_W-1:0] r_line  [SETS][WAYS];
    logic [WAY_W-1:0]  r_age   [SETS][WAYS];

    logic              w_op_write;
    logic              w_op_inval;
    logic              w_op_lookup;
    logic              w_hit;
    logic [WAY_W-1:0]  w_hit_way;
    logic              w_inv_found;
    logic [WAY_W-1:0]  w_inv_way;
    logic [WAY_W-1:0]  w_max_way;
    logic [WAY_W-1:0]  w_max_age;
    logic [WAY_W-1:0]  w_victim_way;
    logic [WAY_W-1:0]  w_tgt_way;
    logic [WAY_W-1:0]  w_tgt_age;
    logic              w_do_lru;
    logic              w_report_victim;
    logic [WAY_W-1:0]  w_rsp_way;

    assign w_op_write  = (req_op == 2'b01);
    assign w_op_inval  = (req_op == 2'b10);
    assign w_op_lookup = !w_op_write && !w_op_inval;

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[req_index][w] && (r_tag[req_index][w] == req_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
    end

    // Descending scan so the lowest-index invalid way wins.
    always_comb begin
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!r_valid[req_index][w]) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAY_W'(w);
            end
        end
    end

    always_comb begin
        w_max_way = '0;
        w_max_age = r_age[req_index][0];
        for (int w = 1; w < WAYS; w++) begin
            if (r_age[req_index][w] > w_max_age) begin
                w_max_age = r_age[req_index][w];
                w_max_way = WAY_W'(w);
            end
        end
    end

    assign w_victim_way    = w_inv_found ? w_inv_way : w_max_way;
    assign w_tgt_way       = w_hit ? w_hit_way : w_victim_way;
    assign w_tgt_age       = r_age[req_index][w_tgt_way];
    assign w_do_lru        = (w_op_lookup && w_hit) || w_op_write;
    assign w_report_victim = !w_hit && !w_op_inval;
    assign w_rsp_way       = w_op_write ? w_tgt_way : (w_hit ? w_hit_way : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_age[s][w] <= WAY_W'(w);
                end
            end
        end else if (req_valid) begin
            if (w_do_lru) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (r_age[req_index][w] < w_tgt_age) begin
                        r_age[req_index][w] <= r_age[req_index][w] + 1'b1;
                    end
                end
                r_age[req_index][w_tgt_way] <= '0;
            end
            if (w_op_write) begin
                r_valid[req_index][w_tgt_way] <= 1'b1;
                r_dirty[req_index][w_tgt_way] <= req_dirty |
                                                 (w_hit & r_dirty[req_index][w_tgt_way]);
            end else if (w_op_inval && w_hit) begin
                r_valid[req_index][w_hit_way] <= 1'b0;
                r_dirty[req_index][w_hit_way] <= 1'b0;
            end
        end
    end

    // Tag and line storage carry no reset; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (!rst && req_valid && w_op_write) begin
            r_tag[req_index][w_tgt_way]  <= req_tag;
            r_line[req_index][w_tgt_way] <= req_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid        <= 1'b0;
            rsp_hit          <= 1'b0;
            rsp_way          <= '0;
            rsp_data         <= '0;
            rsp_victim_valid <= 1'b0;
            rsp_victim_dirty <= 1'b0;
            rsp_victim_tag   <= '0;
            rsp_victim_data  <= '0;
        end else begin
            rsp_valid <= req_valid;
            if (req_valid) begin
                rsp_hit          <= w_hit;
                rsp_way          <= w_rsp_way;
                rsp_data         <= w_hit ? r_line[req_index][w_hit_way] : '0;
                rsp_victim_valid <= w_report_victim & r_valid[req_index][w_victim_way];
                rsp_victim_dirty <= w_report_victim & r_dirty[req_index][w_victim_way];
                rsp_victim_tag   <= w_report_victim ? r_tag[req_index][w_victim_way] : '0;
                rsp_victim_data  <= w_report_victim ? r_line[req_index][w_victim_way] : '0;
            end
        end
    end

`ifdef SA_CACHE_STATS_EN
    logic [31:0] r_hits;
    logic [31:0] r_misses;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hits   <= '0;
            r_misses <= '0;
        end else if (req_valid && !w_op_inval) begin
            if (w_hit) begin
                if (r_hits != 32'hFFFF_FFFF) r_hits <= r_hits + 32'd1;
            end else begin
                if (r_misses != 32'hFFFF_FFFF) r_misses <= r_misses + 32'd1;
            end
        end
    end

    assign stat_hits   = r_hits;
    assign stat_misses = r_misses;
`endif

endmodule

// File: tb/tb_sa_cache_array.sv
// Self-checking bench for sa_cache_array: directed scenarios plus random ops against a
// recency-list reference model of the set-associative array.
module tb_sa_cache_array;

    localparam int WAYS   = 4;
    localparam int SETS   = 8;
    localparam int TAG_W  = 18;
    localparam int LINE_W = 128;
    localparam int IDX_W  = 3;
    localparam int WAY_W  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic [1:0]        req_op = 2'b00;
    logic [IDX_W-1:0]  req_index = '0;
    logic [TAG_W-1:0]  req_tag = '0;
    logic [LINE_W-1:0] req_data = '0;
    logic              req_dirty = 1'b0;
    logic              rsp_valid;
    logic              rsp_hit;
    logic [WAY_W-1:0]  rsp_way;
    logic [LINE_W-1:0] rsp_data;
    logic              rsp_victim_valid;
    logic              rsp_victim_dirty;
    logic [TAG_W-1:0]  rsp_victim_tag;
    logic [LINE_W-1:0] rsp_victim_data;
`ifdef SA_CACHE_STATS_EN
    logic [31:0]       stat_hits;
    logic [31:0]       stat_misses;
`endif

    sa_cache_array #(
        .WAYS  (WAYS),
        .SETS  (SETS),
        .TAG_W (TAG_W),
        .LINE_W(LINE_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_op          (req_op),
        .req_index       (req_index),
        .req_tag         (req_tag),
        .req_data        (req_data),
        .req_dirty       (req_dirty),
        .rsp_valid       (rsp_valid),
        .rsp_hit         (rsp_hit),
        .rsp_way         (rsp_way),
        .rsp_data        (rsp_data),
        .rsp_victim_valid(rsp_victim_valid),
        .rsp_victim_dirty(rsp_victim_dirty),
        .rsp_victim_tag  (rsp_victim_tag),
        .rsp_victim_data (rsp_victim_data)
`ifdef SA_CACHE_STATS_EN
        ,
        .stat_hits       (stat_hits),
        .stat_misses     (stat_misses)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: per-set recency list, m_order[s][0] is most recently used.
    bit                m_valid [SETS][WAYS];
    bit                m_dirty [SETS][WAYS];
    logic [TAG_W-1:0]  m_tag   [SETS][WAYS];
    logic [LINE_W-1:0] m_line  [SETS][WAYS];
    int                m_order [SETS][WAYS];
    int unsigned       m_hits;
    int unsigned       m_misses;

    logic              e_valid, e_hit, e_vv, e_vd;
    logic [WAY_W-1:0]  e_way;
    logic [LINE_W-1:0] e_data, e_vdata;
    logic [TAG_W-1:0]  e_vt;
    bit                exp_ready = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_order[s][w] = w;
            end
        end
        m_hits   = 0;
        m_misses = 0;
        e_valid = 0; e_hit = 0; e_vv = 0; e_vd = 0;
        e_way = '0; e_data = '0; e_vdata = '0; e_vt = '0;
    endtask

    task automatic touch(input int s, input int w);
        int p = 0;
        for (int i = 0; i < WAYS; i++) if (m_order[s][i] == w) p = i;
        for (int i = p; i > 0; i--) m_order[s][i] = m_order[s][i-1];
        m_order[s][0] = w;
    endtask

    function automatic logic [LINE_W-1:0] line_of(input int t);
        logic [31:0] x;
        x = (32'(t) * 32'h0101_0101) ^ 32'hC0DE_0000;
        return {x, ~x, x + 32'd7, 32'(t)};
    endfunction

    // Drive one op, advance the model, and hand the expected response to the compare process.
    task automatic op(input bit v, input logic [1:0] o, input int idx, input int t,
                      input logic [LINE_W-1:0] d, input bit dy);
        bit hit = 0, rep;
        int hw = 0, vic = -1, tw;
        logic              p_hit, p_vv, p_vd;
        logic [WAY_W-1:0]  p_way;
        logic [LINE_W-1:0] p_data, p_vdata;
        logic [TAG_W-1:0]  p_vt;
        req_valid = v; req_op = o; req_index = IDX_W'(idx);
        req_tag = TAG_W'(t); req_data = d; req_dirty = dy;
        if (v) begin
            for (int w = 0; w < WAYS; w++)
                if (m_valid[idx][w] && m_tag[idx][w] == TAG_W'(t)) begin hit = 1; hw = w; end
            for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[idx][w]) vic = w;
            if (vic < 0) vic = m_order[idx][WAYS-1];
            rep     = !hit && (o != 2'b10);
            tw      = hit ? hw : vic;
            p_hit   = hit;
            p_way   = (o == 2'b01) ? WAY_W'(tw) : (hit ? WAY_W'(hw) : '0);
            p_data  = hit ? m_line[idx][hw] : '0;
            p_vv    = rep && m_valid[idx][vic];
            p_vd    = rep && m_dirty[idx][vic];
            p_vt    = rep ? m_tag[idx][vic] : '0;
            p_vdata = rep ? m_line[idx][vic] : '0;
            if (o == 2'b01) begin
                m_dirty[idx][tw] = dy | (hit & m_dirty[idx][tw]);
                m_valid[idx][tw] = 1'b1;
                m_tag[idx][tw]   = TAG_W'(t);
                m_line[idx][tw]  = d;
                touch(idx, tw);
            end else if (o == 2'b10) begin
                if (hit) begin m_valid[idx][hw] = 1'b0; m_dirty[idx][hw] = 1'b0; end
            end else if (hit) begin
                touch(idx, hw);
            end
            if (o != 2'b10) begin
                if (hit) m_hits++; else m_misses++;
            end
        end
        @(posedge clk);
        e_valid = v;
        if (v) begin
            e_hit = p_hit; e_way = p_way; e_data = p_data;
            e_vv = p_vv; e_vd = p_vd; e_vt = p_vt; e_vdata = p_vdata;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_ready) begin
            chk("rsp_valid", LINE_W'(rsp_valid), LINE_W'(e_valid));
            chk("rsp_hit", LINE_W'(rsp_hit), LINE_W'(e_hit));
            chk("rsp_way", LINE_W'(rsp_way), LINE_W'(e_way));
            chk("rsp_data", rsp_data, e_data);
            chk("victim_valid", LINE_W'(rsp_victim_valid), LINE_W'(e_vv));
            chk("victim_dirty", LINE_W'(rsp_victim_dirty), LINE_W'(e_vd));
            chk("victim_tag", LINE_W'(rsp_victim_tag), LINE_W'(e_vt));
            chk("victim_data", rsp_victim_data, e_vdata);
`ifdef SA_CACHE_STATS_EN
            chk("stat_hits", LINE_W'(stat_hits), LINE_W'(m_hits));
            chk("stat_misses", LINE_W'(stat_misses), LINE_W'(m_misses));
`endif
        end
    end

    initial begin
        logic [LINE_W-1:0] a5;
        logic [LINE_W-1:0] rd;
        int r;
        a5 = {16{8'hA5}};
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Cold miss after reset.
        op(1, 2'b00, 5, 1, '0, 0);
        chk("lit_cold_valid", LINE_W'(rsp_valid), LINE_W'(1));
        chk("lit_cold_hit", LINE_W'(rsp_hit), LINE_W'(0));
        chk("lit_cold_vv", LINE_W'(rsp_victim_valid), LINE_W'(0));
        chk("lit_cold_way", LINE_W'(rsp_way), LINE_W'(0));

        op(1, 2'b01, 5, 1, a5, 0);
        op(1, 2'b00, 5, 1, '0, 0);
        chk("lit_wr_hit", LINE_W'(rsp_hit), LINE_W'(1));
        chk("lit_wr_way", LINE_W'(rsp_way), LINE_W'(0));
        chk("lit_wr_data", rsp_data, a5);

        // Fill set 7, refresh tag 1, allocate tag 5 over the LRU way (tag 2).
        for (int t = 1; t <= 4; t++) op(1, 2'b01, 7, t, line_of(t), 0);
        op(1, 2'b00, 7, 1, '0, 0);
        op(1, 2'b01, 7, 5, line_of(5), 0);
        chk("lit_lru_vv", LINE_W'(rsp_victim_valid), LINE_W'(1));
        chk("lit_lru_vt", LINE_W'(rsp_victim_tag), LINE_W'(2));
        chk("lit_lru_way", LINE_W'(rsp_way), LINE_W'(1));

        // Dirty line tag 6 lands in way 2, then four more misses push it out.
        op(1, 2'b01, 7, 6, line_of(6), 1);
        chk("lit_t6_vt", LINE_W'(rsp_victim_tag), LINE_W'(3));
        for (int t = 7; t <= 9; t++) op(1, 2'b01, 7, t, line_of(t), 0);
        op(1, 2'b01, 7, 10, line_of(10), 0);
        chk("lit_evict_vd", LINE_W'(rsp_victim_dirty), LINE_W'(1));
        chk("lit_evict_vt", LINE_W'(rsp_victim_tag), LINE_W'(6));
        chk("lit_evict_vdata", rsp_victim_data, line_of(6));

        // Invalidate tag 9 (way 1); next allocation reuses it.
        op(1, 2'b10, 7, 9, '0, 0);
        chk("lit_inv_hit", LINE_W'(rsp_hit), LINE_W'(1));
        chk("lit_inv_data", rsp_data, line_of(9));
        op(1, 2'b00, 7, 9, '0, 0);
        chk("lit_inv_miss", LINE_W'(rsp_hit), LINE_W'(0));
        op(1, 2'b01, 7, 11, line_of(11), 1);
        chk("lit_reuse_way", LINE_W'(rsp_way), LINE_W'(1));
        chk("lit_reuse_vv", LINE_W'(rsp_victim_valid), LINE_W'(0));

        // Idle cycle: rsp_valid drops, other fields hold.
        op(0, 2'b00, 0, 0, '0, 0);

        // Random traffic with a small tag pool to force hits, conflicts and evictions.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9);
            rd = {$urandom, $urandom, $urandom, $urandom};
            op($urandom_range(0, 9) != 0,
               (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11,
               $urandom_range(0, SETS - 1), $urandom_range(0, 9), rd, $urandom_range(0, 1) == 1);
        end

        // Reset while a LOOKUP response is outstanding.
        req_valid = 1; req_op = 2'b00; req_index = 3'd5; req_tag = 18'd1;
        @(posedge clk);
        #1 rst = 1'b1;
        req_valid = 0;
        model_reset();
        @(negedge clk);
        chk("lit_rst_valid", LINE_W'(rsp_valid), LINE_W'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        op(0, 2'b00, 0, 0, '0, 0);
        chk("lit_post_rst_valid", LINE_W'(rsp_valid), LINE_W'(0));
        op(1, 2'b00, 5, 1, '0, 0);
        chk("lit_post_rst_hit", LINE_W'(rsp_hit), LINE_W'(0));
        op(1, 2'b00, 7, 11, '0, 0);
        chk("lit_post_rst_hit7", LINE_W'(rsp_hit), LINE_W'(0));
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
